// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - packed float format, pack-stage state encoding and constants
package fp_pkg;

    localparam int MB = 23;
    localparam int EB = 8;
    localparam int FP_BIAS = (2 ** (EB - 1)) - 1;

    typedef struct packed {
        logic          sign;
        logic [EB-1:0] exp;
        logic [MB-1:0] mant;
    } fp;

    typedef enum logic [1:0] {
        PS_IDLE  = 2'd0,
        PS_NORM  = 2'd1,
        PS_ROUND = 2'd2,
        PS_HOLD  = 2'd3
    } pack_state_t;

    localparam fp FP_QNAN   = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
    localparam fp FP_MAXFIN = {1'b0, {(EB-1){1'b1}}, 1'b0, {MB{1'b1}}};

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even of a mantissa
module fp_round_rne #(
    parameter int MB = 23,
    parameter int XW = 10
) (
    input  logic [MB-1:0]        mant_i,
    input  logic                 guard_i,
    input  logic                 sticky_i,
    input  logic signed [XW-1:0] exp_i,
    output logic [MB-1:0]        mant_o,
    output logic signed [XW-1:0] exp_o,
    output logic                 carry_o
);
    logic          round_up;
    logic [MB:0]   sum;

    always_comb begin
        round_up = guard_i & (sticky_i | mant_i[0]);
        sum      = {1'b0, mant_i} + {{MB{1'b0}}, round_up};
        carry_o  = sum[MB];
        // on carry-out the low MB bits are already zero
        mant_o   = sum[MB-1:0];
        exp_o    = exp_i + {{(XW-1){1'b0}}, carry_o};
    end

endmodule

// File: rtl/fp_pack_norm.sv
// rtl/fp_pack_norm.sv - sequential normalize, round and pack into fp format
module fp_pack_norm
    import fp_pkg::*;
#(
    parameter int WB = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [EB+1:0] in_exp,
    input  logic [WB-1:0]        in_sig,
    input  logic                 in_zero,
    input  logic                 in_inf,
    input  logic                 in_nan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output fp                    out_fp,
    output logic                 out_ovf,
    output logic                 out_unf,
    output logic                 out_inexact
);
    localparam int XW = EB + 2;
    localparam int GB = WB - 3 - MB;
    localparam logic [WB-1:0]        LOW_MASK = (WB'(1) << GB) - WB'(1);
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_SAT  = XW'((2 ** EB) - 1);

    pack_state_t          state_q;
    logic [WB-1:0]        sig_q;
    logic signed [XW-1:0] exp_q;
    logic                 sticky_q;
    logic                 sign_q;
    fp                    fp_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 inexact_q;

    logic [MB-1:0]        rnd_mant;
    logic signed [XW-1:0] rnd_exp;
    logic                 rnd_carry;
    logic                 guard;
    logic                 sticky_all;
    logic                 denorm;
    logic                 ovf;
    logic signed [XW-1:0] exp_fin;

    fp_round_rne #(
        .MB(MB),
        .XW(XW)
    ) u_round (
        .mant_i  (sig_q[WB-3 -: MB]),
        .guard_i (guard),
        .sticky_i(sticky_all),
        .exp_i   (exp_q),
        .mant_o  (rnd_mant),
        .exp_o   (rnd_exp),
        .carry_o (rnd_carry)
    );

    // A denormal that rounds into the hidden bit becomes the smallest normal.
    always_comb begin
        guard      = sig_q[GB];
        sticky_all = sticky_q | (|(sig_q & LOW_MASK));
        denorm     = (exp_q == EXP_ONE) && !sig_q[WB-2];
        exp_fin    = denorm ? {{(XW-1){1'b0}}, rnd_carry} : rnd_exp;
        ovf        = (exp_fin >= EXP_SAT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PS_IDLE;
            sig_q     <= '0;
            exp_q     <= '0;
            sticky_q  <= 1'b0;
            sign_q    <= 1'b0;
            fp_q      <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            case (state_q)
                PS_IDLE: begin
                    if (in_valid) begin
                        sign_q    <= in_sign;
                        ovf_q     <= 1'b0;
                        unf_q     <= 1'b0;
                        inexact_q <= 1'b0;
                        if (in_nan) begin
                            fp_q    <= FP_QNAN;
                            state_q <= PS_HOLD;
                        end else if (in_inf) begin
                            fp_q    <= {in_sign, {EB{1'b1}}, {MB{1'b1}}};
                            state_q <= PS_HOLD;
                        end else if (in_zero) begin
                            fp_q    <= {in_sign, {(EB+MB){1'b0}}};
                            state_q <= PS_HOLD;
                        end else begin
                            sig_q    <= in_sig;
                            exp_q    <= in_exp;
                            sticky_q <= 1'b0;
                            state_q  <= PS_NORM;
                        end
                    end
                end
                PS_NORM: begin
                    if (sig_q == '0) begin
                        fp_q    <= {sign_q, {(EB+MB){1'b0}}};
                        state_q <= PS_HOLD;
                    end else if (sig_q[WB-1]) begin
                        sig_q    <= sig_q >> 1;
                        sticky_q <= sticky_q | sig_q[0];
                        exp_q    <= exp_q + EXP_ONE;
                    end else if (exp_q < EXP_ONE) begin
                        fp_q      <= {sign_q, {(EB+MB){1'b0}}};
                        unf_q     <= 1'b1;
                        inexact_q <= 1'b1;
                        state_q   <= PS_HOLD;
                    end else if (!sig_q[WB-2] && (exp_q > EXP_ONE)) begin
                        sig_q <= sig_q << 1;
                        exp_q <= exp_q - EXP_ONE;
                    end else begin
                        state_q <= PS_ROUND;
                    end
                end
                PS_ROUND: begin
                    state_q <= PS_HOLD;
                    if (ovf) begin
                        fp_q      <= {sign_q, FP_MAXFIN[EB+MB-1:0]};
                        ovf_q     <= 1'b1;
                        inexact_q <= 1'b1;
                    end else begin
                        fp_q      <= {sign_q, exp_fin[EB-1:0], rnd_mant};
                        inexact_q <= guard | sticky_all;
                    end
                end
                PS_HOLD: begin
                    if (out_ready) begin
                        state_q <= PS_IDLE;
                    end
                end
                default: state_q <= PS_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == PS_IDLE);
    assign out_valid   = (state_q == PS_HOLD);
    assign out_fp      = fp_q;
    assign out_ovf     = ovf_q;
    assign out_unf     = unf_q;
    assign out_inexact = inexact_q;

endmodule
